// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared types, default sizes and lane helper for the TDM demux.
package tdm_demux_pkg;
  typedef enum logic {HUNT, FILL} state_t;
  localparam int DEF_N_LANES = 8;
  localparam int DEF_WIDTH = 1;
  function automatic logic [DEF_WIDTH-1:0] lane_get(input logic [DEF_N_LANES*DEF_WIDTH-1:0] frame, input int k);
    return frame[k*DEF_WIDTH +: DEF_WIDTH];
  endfunction
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: slot counter with wrap at MAX, sync-load to 1 and clear.
module tdm_slot_ctr #(
  parameter int CW = 3,
  parameter int MAX = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          ld,
  input  logic          inc,
  output logic [CW-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (ld) cnt <= CW'(1);
    else if (inc) cnt <= (cnt == CW'(MAX)) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/tdm_demux8.sv
// tdm_demux8: serial-to-parallel TDM demux with frame handshake.
// Define TDM_DEMUX8_PARITY_EN to add a trailing even-parity slot per frame.
module tdm_demux8
  import tdm_demux_pkg::*;
#(
  parameter int N_LANES = DEF_N_LANES,
  parameter int WIDTH = DEF_WIDTH,
  localparam int SEL_W = $clog2(N_LANES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_valid,
  input  logic                     sync,
  output logic [N_LANES*WIDTH-1:0] lanes,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [SEL_W-1:0]         slot,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     par_err
);
`ifdef TDM_DEMUX8_PARITY_EN
  localparam int CW = SEL_W + 1;
  localparam int LAST = N_LANES;
`else
  localparam int CW = SEL_W;
  localparam int LAST = N_LANES - 1;
`endif
  localparam int FW = N_LANES * WIDTH;
  state_t state, state_d;
  logic [FW-1:0] shadow, shadow_d;
  logic [CW-1:0] cnt;
  logic ld, clr, inc, done, pub, ferr_d, perr_d, fv_d, ovr_d;
  tdm_slot_ctr #(.CW(CW), .MAX(LAST)) u_ctr (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .inc(inc), .cnt(cnt)
  );
  assign slot = cnt[SEL_W-1:0];
  always_comb begin
    ld = din_valid && sync;
    clr = din_valid && !sync && state == FILL && cnt == '0;
    inc = din_valid && !sync && state == FILL && cnt != '0;
    done = inc && cnt == CW'(LAST);
    ferr_d = clr || (ld && state == FILL && cnt != '0);
    state_d = ld ? FILL : clr ? HUNT : state;
    shadow_d = shadow;
    for (int k = 0; k < N_LANES; k++)
      shadow_d[k*WIDTH +: WIDTH] = ((ld && k == 0) || (inc && cnt == CW'(k))) ? din : shadow[k*WIDTH +: WIDTH];
`ifdef TDM_DEMUX8_PARITY_EN
    perr_d = done && ((^shadow) != din[0]);
`else
    perr_d = 1'b0;
`endif
    pub = done && !perr_d;
    fv_d = pub || (frame_valid && !frame_ready);
    ovr_d = pub && frame_valid && !frame_ready;
  end
  // Lanes only load on a published frame, so the held frame is isolated from the shadow.
  always_ff @(posedge clk)
    if (rst) begin
      state <= HUNT;
      shadow <= '0;
      lanes <= '0;
      frame_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      par_err <= 1'b0;
    end else begin
      state <= state_d;
      shadow <= shadow_d;
      if (pub) lanes <= shadow_d;
      frame_valid <= fv_d;
      frame_err <= ferr_d;
      overrun <= ovr_d;
      par_err <= perr_d;
    end
endmodule
